// File: rtl/hex_display_scheduler.sv
// Shares one hex decoder among N_DIGITS positions and three value sources.
// Define HEX_BLANK_LEADING_EN to drive digit_blank for leading zeros.
module hex_display_scheduler #(
    parameter int N_DIGITS    = 4,
    parameter int SCAN_DIV    = 1024,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [4*N_DIGITS-1:0] base_val,
    input  logic [4*N_DIGITS-1:0] ovl_a_val,
    input  logic                  ovl_a_req,
    input  logic [4*N_DIGITS-1:0] ovl_b_val,
    input  logic                  ovl_b_req,
    output logic [3:0]            digit_nib,
    output logic [N_DIGITS-1:0]   digit_en_n,
    output logic [1:0]            active_src,
    output logic                  digit_blank
);
    localparam int IW = $clog2(N_DIGITS);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int HW = $clog2(HOLD_CYCLES);
    localparam int DW = 4 * N_DIGITS;

    typedef enum logic [1:0] {
        SHOW_BASE = 2'd0,
        SHOW_A    = 2'd1,
        SHOW_B    = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [HW-1:0] r_hold;
    logic [HW-1:0] w_hold_nxt;
    logic [SW-1:0] r_scan;
    logic [IW-1:0] r_idx;
    logic [DW-1:0] r_snap;
    logic [DW-1:0] r_ovl_a;
    logic [DW-1:0] r_ovl_b;
    logic [DW-1:0] w_owner_val;
    logic          w_cap_a;
    logic          w_cap_b;
    logic          w_scan_tc;
    logic          w_frame_wrap;

    assign w_scan_tc    = (r_scan == SW'(SCAN_DIV - 1));
    assign w_frame_wrap = w_scan_tc && (r_idx == IW'(N_DIGITS - 1));

    // B beats A; a request on the expiry cycle beats the expiry
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_cap_a     = 1'b0;
        w_cap_b     = 1'b0;
        if (ovl_b_req) begin
            w_state_nxt = SHOW_B;
            w_hold_nxt  = HW'(HOLD_CYCLES - 1);
            w_cap_b     = 1'b1;
        end else if (ovl_a_req && (r_state != SHOW_B)) begin
            w_state_nxt = SHOW_A;
            w_hold_nxt  = HW'(HOLD_CYCLES - 1);
            w_cap_a     = 1'b1;
        end else if (r_state != SHOW_BASE) begin
            if (r_hold == '0) begin
                w_state_nxt = SHOW_BASE;
            end else begin
                w_hold_nxt = r_hold - HW'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= SHOW_BASE;
            r_hold  <= '0;
            r_ovl_a <= '0;
            r_ovl_b <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            if (w_cap_a) r_ovl_a <= ovl_a_val;
            if (w_cap_b) r_ovl_b <= ovl_b_val;
        end
    end

    always_comb begin
        case (r_state)
            SHOW_A:  w_owner_val = r_ovl_a;
            SHOW_B:  w_owner_val = r_ovl_b;
            default: w_owner_val = base_val;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_scan <= '0;
            r_idx  <= '0;
            r_snap <= '0;
        end else begin
            r_scan <= w_scan_tc ? '0 : r_scan + SW'(1);
            if (w_scan_tc) begin
                r_idx <= w_frame_wrap ? '0 : r_idx + IW'(1);
            end
            if (w_frame_wrap) r_snap <= w_owner_val;
        end
    end

    always_comb begin
        digit_nib = 4'd0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r_idx == IW'(i)) digit_nib = r_snap[4*i +: 4];
        end
    end

    assign digit_en_n = ~(N_DIGITS'(1) << r_idx);
    assign active_src = r_state;

`ifdef HEX_BLANK_LEADING_EN
    always_comb begin
        digit_blank = (r_idx != '0);
        for (int i = 0; i < N_DIGITS; i++) begin
            if ((IW'(i) >= r_idx) && (r_snap[4*i +: 4] != 4'd0)) begin
                digit_blank = 1'b0;
            end
        end
    end
`else
    assign digit_blank = 1'b0;
`endif

endmodule
